// File: rtl/serial_eq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : serial_eq_checker
//  Description : Compares two serial bit streams word by word. Each accepted
//                beat carries one A/B bit pair; after WIDTH beats the number
//                of unequal pairs and an all-equal flag are presented on a
//                valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_eq_checker #(
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           a_bit,
    input  logic                           b_bit,
    input  logic                           in_valid,
    input  logic                           frame_start,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           match,
    output logic [$clog2(WIDTH+1)-1:0]     mismatch_cnt,
    output logic                           eq_bit
);

    localparam int CW = $clog2(WIDTH + 1);

    // Index of the last bit of a word, and the saturation ceiling of the count
    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_max_cnt  = CW'(WIDTH);
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam logic [CW-1:0] c_zero     = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_bit_cnt;
    logic [CW-1:0]   r_run_cnt;
    logic            r_out_valid;
    logic            r_match;
    logic [CW-1:0]   r_mismatch_cnt;
    logic            r_eq_bit;

    logic            w_eq;
    logic            w_accept;
    logic [CW-1:0]   w_first_cnt;
    logic [CW-1:0]   w_next_cnt;

    // Per-beat equality and the running count as it would stand after this beat
    always_comb begin
        w_eq        = (a_bit & b_bit) | (~a_bit & ~b_bit);
        w_accept    = in_valid & in_ready;
        w_first_cnt = w_eq ? c_zero : c_one;
        if (w_eq) begin
            w_next_cnt = r_run_cnt;
        end else if (r_run_cnt >= c_max_cnt) begin
            w_next_cnt = c_max_cnt;
        end else begin
            w_next_cnt = r_run_cnt + c_one;
        end
    end

    // Ready depends on state only: the block stalls only while a result is pending
    assign in_ready     = (r_state != S_DONE);
    assign out_valid    = r_out_valid;
    assign match        = r_match;
    assign mismatch_cnt = r_mismatch_cnt;
    assign eq_bit       = r_eq_bit;

    // Word-accumulation state machine with registered result outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= c_zero;
            r_run_cnt      <= c_zero;
            r_out_valid    <= 1'b0;
            r_match        <= 1'b0;
            r_mismatch_cnt <= c_zero;
            r_eq_bit       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_eq_bit <= w_eq;
            end
            case (r_state)
                S_IDLE: begin
                    // Any accepted beat here is bit 0, frame_start or not
                    if (w_accept) begin
                        r_bit_cnt <= c_one;
                        r_run_cnt <= w_first_cnt;
                        r_state   <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        if (frame_start) begin
                            // Drop the partial word; this beat becomes bit 0
                            r_bit_cnt <= c_one;
                            r_run_cnt <= w_first_cnt;
                        end else if (r_bit_cnt == c_last_bit) begin
                            r_mismatch_cnt <= w_next_cnt;
                            r_match        <= (w_next_cnt == c_zero);
                            r_out_valid    <= 1'b1;
                            r_bit_cnt      <= c_zero;
                            r_run_cnt      <= c_zero;
                            r_state        <= S_DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_one;
                            r_run_cnt <= w_next_cnt;
                        end
                    end
                end
                S_DONE: begin
                    // Result held until the consumer takes it
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_eq_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_eq_checker
//  Description : Self-checking bench for serial_eq_checker (WIDTH=4): directed
//                scenarios followed by randomized traffic, each cycle compared
//                against a word-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_eq_checker;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic          clk;
    logic          rst_n;
    logic          a_bit;
    logic          b_bit;
    logic          in_valid;
    logic          frame_start;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          match;
    logic [CW-1:0] mismatch_cnt;
    logic          eq_bit;

    int checks   = 0;
    int failures = 0;

    // Reference model: bits collected so far for the open word, plus the pending result
    int m_a[$];
    int m_b[$];
    bit m_pending;
    int m_cnt;
    bit m_match;
    bit m_eq;

    serial_eq_checker #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_bit        (a_bit),
        .b_bit        (b_bit),
        .in_valid     (in_valid),
        .frame_start  (frame_start),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .match        (match),
        .mismatch_cnt (mismatch_cnt),
        .eq_bit       (eq_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output with the model
    task automatic check_all(input string tag);
        check({tag, ".in_ready"},     32'(in_ready),     32'(!m_pending));
        check({tag, ".out_valid"},    32'(out_valid),    32'(m_pending));
        check({tag, ".match"},        32'(match),        32'(m_match));
        check({tag, ".mismatch_cnt"}, 32'(mismatch_cnt), 32'(m_cnt));
        check({tag, ".eq_bit"},       32'(eq_bit),       32'(m_eq));
    endtask

    // One clock cycle: drive inputs, clock, advance the model, compare
    task automatic step(input string tag, input bit rstn, input bit v, input bit a,
                        input bit b, input bit fs, input bit rdy);
        bit accept;
        int miss;
        rst_n       = rstn;
        in_valid    = v;
        a_bit       = a;
        b_bit       = b;
        frame_start = fs;
        out_ready   = rdy;
        accept      = v && !m_pending;
        @(posedge clk);
        #1;
        if (!rstn) begin
            m_a.delete();
            m_b.delete();
            m_pending = 0;
            m_cnt     = 0;
            m_match   = 0;
            m_eq      = 0;
        end else if (accept) begin
            m_eq = (a == b);
            if (fs) begin
                m_a.delete();
                m_b.delete();
            end
            m_a.push_back(int'(a));
            m_b.push_back(int'(b));
            if (m_a.size() == WIDTH) begin
                miss = 0;
                foreach (m_a[i]) if (m_a[i] != m_b[i]) miss++;
                m_cnt     = miss;
                m_match   = (miss == 0);
                m_pending = 1;
                m_a.delete();
                m_b.delete();
            end
        end else if (m_pending && rdy) begin
            m_pending = 0;
        end
        check_all(tag);
    endtask

    task automatic word(input string tag, input logic [3:0] a, input logic [3:0] b);
        for (int i = 3; i >= 0; i--) step(tag, 1, 1, a[i], b[i], 0, 0);
    endtask

    initial begin
        rst_n = 0; in_valid = 0; a_bit = 0; b_bit = 0; frame_start = 0; out_ready = 0;
        m_pending = 0; m_cnt = 0; m_match = 0; m_eq = 0;

        // Reset values and readiness right after release
        step("reset", 0, 0, 0, 0, 0, 0);
        step("reset2", 0, 1, 1, 0, 1, 1);
        step("post_reset", 1, 0, 0, 0, 0, 0);
        check("post_reset.ready_first", 32'(in_ready), 32'd1);

        // Fully equal word, then take result
        word("eq_word", 4'b1011, 4'b1011);
        check("eq_word.match_lit", 32'(match), 32'd1);
        step("eq_take", 1, 0, 0, 0, 0, 1);

        // Fully unequal word
        word("neq_word", 4'b1011, 4'b0100);
        check("neq_word.cnt_lit", 32'(mismatch_cnt), 32'd4);
        step("neq_take", 1, 0, 0, 0, 0, 1);

        // Gap of two idle cycles between beats 1 and 2
        step("gap", 1, 1, 1, 1, 0, 0);
        step("gap", 1, 1, 1, 0, 0, 0);
        step("gap", 1, 0, 1, 1, 0, 0);
        step("gap", 1, 0, 0, 1, 0, 0);
        step("gap", 1, 1, 0, 0, 0, 0);
        step("gap", 1, 1, 0, 1, 0, 0);
        check("gap.cnt_lit", 32'(mismatch_cnt), 32'd2);

        // Back-pressure: result held three cycles while beats are offered
        step("hold", 1, 1, 1, 0, 1, 0);
        step("hold", 1, 1, 0, 0, 0, 0);
        step("hold", 1, 1, 1, 1, 1, 0);
        step("release", 1, 1, 1, 1, 0, 1);
        check("release.ready_lit", 32'(in_ready), 32'd1);

        // Restart mid-word with frame_start
        step("restart", 1, 1, 1, 0, 0, 0);
        step("restart", 1, 1, 0, 1, 0, 0);
        step("restart", 1, 1, 1, 1, 1, 0);
        step("restart", 1, 1, 0, 0, 0, 0);
        step("restart", 1, 1, 1, 1, 0, 0);
        check("restart.no_early_valid", 32'(out_valid), 32'd0);
        step("restart", 1, 1, 0, 0, 0, 0);
        check("restart.match_lit", 32'(match), 32'd1);
        step("restart_take", 1, 0, 0, 0, 0, 1);

        // Reset in the middle of a word
        step("abort", 1, 1, 1, 0, 0, 0);
        step("abort", 1, 1, 0, 1, 0, 0);
        step("abort_rst", 0, 0, 0, 0, 0, 0);
        word("after_abort", 4'b0110, 4'b0110);
        check("after_abort.cnt_lit", 32'(mismatch_cnt), 32'd0);
        // Reset while a result is pending
        step("pending_rst", 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step("rand",
                 ($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout checks=%0d", checks);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_eq_checker.md
SERIAL_EQ_CHECKER -- requirements
Module: serial_eq_checker

Interface
REQ-001 Parameter WIDTH, default 8: number of bit pairs per compared word; legal range 2..64.
REQ-002 Derived width CW = ceil(log2(WIDTH+1)): width of the mismatch count.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 a_bit  input  1  serial operand A, one bit per accepted beat.
REQ-006 b_bit  input  1  serial operand B, one bit per accepted beat.
REQ-007 in_valid  input  1  a_bit/b_bit valid this cycle.
REQ-008 frame_start  input  1  qualifies an accepted beat as bit 0 of a new word.
REQ-009 in_ready  output  1  block can accept a beat this cycle.
REQ-010 out_valid  output  1  word result available.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 match  output  1  all WIDTH bit pairs of the word were equal.
REQ-013 mismatch_cnt  output  CW  number of unequal bit pairs in the word.
REQ-014 eq_bit  output  1  registered XNOR of the last accepted a_bit/b_bit pair.

Function
REQ-015 A beat is accepted only in a cycle where in_valid=1 and in_ready=1; cycles without acceptance change no state.
REQ-016 Per-beat equality is eq = (a AND b) OR (NOT a AND NOT b); eq_bit is updated with eq on every accepted beat and holds otherwise.
REQ-017 The state machine has three states: IDLE, ACCUM and DONE.
REQ-018 in_ready is 1 in IDLE and ACCUM and 0 in DONE; it is a function of the state only.
REQ-019 IDLE: an accepted beat, with or without frame_start, is bit 0; the bit counter is set to 1, the running count to (eq ? 0 : 1), and the next state is ACCUM.
REQ-020 ACCUM: an accepted beat with frame_start=0 increments the bit counter and adds 1 to the running count when eq=0.
REQ-021 ACCUM: an accepted beat with frame_start=1 discards the partial word and restarts as in REQ-019; the state remains ACCUM.
REQ-022 When the accepted beat is bit WIDTH-1, the next state is DONE; the final count is latched into mismatch_cnt and match is set to (final count == 0).
REQ-023 Latency: out_valid rises in the cycle immediately after the beat that completes the word is accepted.
REQ-024 DONE: out_valid=1; match and mismatch_cnt hold stable until the handshake completes, regardless of in_valid or frame_start.
REQ-025 DONE with out_ready=1: the handshake completes, the next state is IDLE, and out_valid is 0 in the following cycle; the first beat of the next word is accepted one cycle later at the earliest.
REQ-026 The running count saturates at WIDTH and never wraps; mismatch_cnt is never greater than WIDTH.
REQ-027 match and mismatch_cnt keep their last result values while in IDLE and ACCUM.
REQ-028 out_ready is ignored outside DONE.

Reset
REQ-029 With rst_n=0 at a rising edge, the following apply at that edge: state=IDLE, bit counter=0, running count=0, out_valid=0, match=0, mismatch_cnt=0, eq_bit=0.
REQ-030 A reset at any point, including mid-word in ACCUM or while results are pending in DONE, discards the partial word or pending result; no out_valid is issued for it.
REQ-031 in_ready is 1 in the first cycle after reset is released.

Verification (WIDTH=4, bits listed in acceptance order)
REQ-032 A=1,0,1,1 and B=1,0,1,1 on back-to-back beats, out_ready=1 -> one cycle after beat 3, out_valid=1, match=1, mismatch_cnt=0; eq_bit=1 after every beat.
REQ-033 A=1,0,1,1 and B=0,1,0,0 -> match=0, mismatch_cnt=4; eq_bit=0 after each beat.
REQ-034 A=1,1,0,0 and B=1,0,0,1, with in_valid low for 2 cycles between beats 1 and 2 -> match=0, mismatch_cnt=2; the result is unaffected by the gap.
REQ-035 Result pending with out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, no beat accepted, outputs stable; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
REQ-036 Two mismatching beats, then frame_start=1 with 4 equal beats -> a single out_valid with match=1, mismatch_cnt=0.
REQ-037 rst_n=0 after 2 beats of a word, then 4 equal beats -> no result for the aborted word; the next result has match=1, mismatch_cnt=0.
